// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl
//   Sequencer in front of a 1-to-8 demux. It takes one DATA_W-bit word at a
//   time from an upstream valid/ready source, together with a 3-bit
//   destination. It waits for the addressed sink to be ready and then shifts
//   the word out MSB-first on the demux data line. If the sink never becomes
//   ready, the word is dropped after TIMEOUT wait cycles.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream word valid
//   in_ready   high only in IDLE (decoded from state)
//   in_dest    destination sink index, sampled on handshake only
//   in_data    word payload, sampled on handshake only
//   dst_ready  per-sink ready, bit i <-> demux output f[i]
//   s          demux select, holds dest from handshake until the next handshake
//   a          demux serial data, MSB first, 0 outside SEND
//   frame      one-hot sink currently receiving bits, else 0
//   done       1-cycle pulse after the last bit of a word
//   drop       1-cycle pulse when a word is discarded on timeout
//   busy       high in every state except IDLE
//
// State table
//   IDLE | ready for a word
//   WAIT | word latched, polling dst_ready[s], counting toward TIMEOUT
//   SEND | shifting DATA_W bits out on a, frame asserted
//   GAP  | GAP_CYC quiet cycles before the next word
module demux_route_ctrl #(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic [7:0]        dst_ready,
  output logic [2:0]        s,
  output logic              a,
  output logic [7:0]        frame,
  output logic              done,
  output logic              drop,
  output logic              busy
);

  localparam int BW = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_e;

  state_e            state_q;
  logic [2:0]        s_q;
  logic [DATA_W-1:0] sh_q;
  logic [BW-1:0]     bcnt_q;
  logic [TW-1:0]     tcnt_q;
  logic [GW-1:0]     gcnt_q;
  logic              a_q;
  logic [7:0]        frame_q;
  logic              done_q;
  logic              drop_q;

  // After a word ends (sent or dropped) either rest in GAP or go straight home.
  localparam state_e POST_STATE = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      a_q     <= 1'b0;
      frame_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            s_q     <= in_dest;
            sh_q    <= in_data;
            tcnt_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dst_ready[s_q]) begin
            // First bit is registered here so it appears in the first SEND cycle.
            frame_q <= 8'b1 << s_q;
            a_q     <= sh_q[DATA_W-1];
            sh_q    <= sh_q << 1;
            bcnt_q  <= '0;
            state_q <= S_SEND;
          end else if ((TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
            drop_q  <= 1'b1;
            gcnt_q  <= '0;
            state_q <= POST_STATE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_SEND: begin
          // dst_ready is not looked at here: a started word always completes.
          if (bcnt_q == BW'(DATA_W - 1)) begin
            frame_q <= '0;
            a_q     <= 1'b0;
            done_q  <= 1'b1;
            gcnt_q  <= '0;
            state_q <= POST_STATE;
          end else begin
            a_q    <= sh_q[DATA_W-1];
            sh_q   <= sh_q << 1;
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        S_GAP: begin
          if (gcnt_q == GW'(GAP_CYC - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign s        = s_q;
  assign a        = a_q;
  assign frame    = frame_q;
  assign done     = done_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_demux_route_ctrl.sv
module tb_demux_route_ctrl;

  localparam int DW      = 8;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_dest = '0;
  logic [DW-1:0] in_data = '0;
  logic [7:0]    dst_ready = '0;
  logic [2:0]    s;
  logic          a;
  logic [7:0]    frame;
  logic          done;
  logic          drop;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  demux_route_ctrl #(.DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .dst_ready (dst_ready),
    .s         (s),
    .a         (a),
    .frame     (frame),
    .done      (done),
    .drop      (drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {s, a, frame, done, drop, busy, in_ready}.
  function automatic logic [15:0] observed();
    return {s, a, frame, done, drop, busy, in_ready};
  endfunction

  // Timeline model of one word. Cycle 0 is the handshake cycle, cycle n is the
  // n-th cycle after it. The sink becomes ready after k low WAIT cycles.
  function automatic logic [15:0] model_word(input int n, input logic [2:0] dest,
                                             input logic [DW-1:0] data, input int k);
    int          t_end, s0, dn;
    logic        ea, edone, edrop, eidle;
    logic [7:0]  efr;
    ea = 1'b0; edone = 1'b0; edrop = 1'b0; efr = '0;
    if (k >= TIMEOUT) begin
      t_end = TIMEOUT + 1 + GAP;
      edrop = (n == TIMEOUT + 1);
    end else begin
      s0    = k + 2;
      dn    = k + 2 + DW;
      t_end = dn + GAP;
      if (n >= s0 && n < dn) begin
        efr = 8'(1 << dest);
        ea  = data[DW-1-(n-s0)];
      end
      edone = (n == dn);
    end
    eidle = (n >= t_end);
    return {dest, ea, efr, edone, edrop, ~eidle, eidle};
  endfunction

  function automatic int word_len(input int k);
    return (k >= TIMEOUT) ? (TIMEOUT + 1 + GAP) : (k + 2 + DW + GAP);
  endfunction

  // Starts at a negedge, ends at the negedge of the IDLE cycle after the word.
  task automatic run_word(input string name, input logic [2:0] dest, input logic [DW-1:0] data,
                          input int k, input bit quiet_send);
    logic [15:0] exp;
    logic [7:0]  rdy;
    int          t_end;
    int          w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
      return;
    end
    in_valid  = 1'b1;
    in_dest   = dest;
    in_data   = data;
    dst_ready = 8'($urandom);
    t_end     = word_len(k);
    for (int n = 1; n <= t_end; n++) begin
      @(negedge clk);
      exp = model_word(n, dest, data, k);
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL %s cyc%0d {s,a,frame,done,drop,busy,rdy}: got %h required %h",
                 name, n, observed(), exp);
      end
      in_valid = 1'b0;
      in_dest  = 3'($urandom);
      in_data  = DW'($urandom);
      rdy = 8'($urandom);
      if (n <= k)           rdy[dest] = 1'b0;
      else if (n == k + 1)  rdy[dest] = 1'b1;
      else if (quiet_send)  rdy = '0;
      dst_ready = rdy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (observed() !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_held: got %h required %h", observed(), 16'h0001);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (observed() !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", observed(), 16'h0001);
    end
  endtask

  task automatic test_basic();
    run_word("basic_a5", 3'd5, 8'hA5, 0, 1'b0);
  endtask

  task automatic test_wait();
    run_word("wait4", 3'd2, 8'h96, 4, 1'b0);
  endtask

  task automatic test_timeout();
    run_word("timeout", 3'd7, 8'hC3, 1000, 1'b0);
    run_word("tmo_edge14", 3'd1, 8'h5A, TIMEOUT - 1, 1'b0);
    run_word("tmo_edge15", 3'd6, 8'h81, TIMEOUT, 1'b0);
  endtask

  task automatic test_ready_drop_in_send();
    run_word("send_unready", 3'd4, 8'hE7, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    in_valid  = 1'b1;
    in_dest   = 3'd3;
    in_data   = 8'hFF;
    dst_ready = 8'hFF;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_checks++;
    if (frame !== 8'h08 || a !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_send4: frame=%h a=%b required 08 1", frame, a);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (observed() !== 16'h0001) begin
      n_fail++;
      $display("FAIL midrst_after: got %h required %h", observed(), 16'h0001);
    end
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || drop !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_quiet cyc%0d: done=%b drop=%b in_ready=%b required 0 0 1",
                 n, done, drop, in_ready);
      end
    end
    run_word("after_midrst", 3'd3, 8'h3C, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int          n_done = 0;
    int          w, m;
    in_valid  = 1'b1;
    in_dest   = 3'd0;
    in_data   = 8'h01;
    dst_ready = 8'hFF;
    for (int n = 1; n <= 88; n++) begin
      @(negedge clk);
      w = (n - 1) / 11;
      m = n - 11 * w;
      exp = model_word(m, 3'(w), 8'(w + 1), 0);
      if (done === 1'b1) n_done++;
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL b2b word%0d cyc%0d: got %h required %h", w, m, observed(), exp);
      end
      if (m == 1 && w < 7) begin
        in_dest = 3'(w + 1);
        in_data = 8'(w + 2);
      end
      if (n == 88) in_valid = 1'b0;
    end
    n_checks++;
    if (n_done != 8) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 8", n_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_word("random", 3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 20)),
               1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_timeout();
    test_ready_drop_in_send();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
